// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC and a single-outstanding req/ack
// imem port, and buffers fetched words in a small queue for decode.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cu_wpcir,
    input  logic                      cu_branch,
    input  logic [31:0]               ID_new_pc,
    output logic                      imem_req,
    output logic [31:0]               imem_addr,
    input  logic                      imem_ack,
    input  logic [31:0]               imem_rdata,
    output logic [31:0]               if_inst,
    output logic [31:0]               if_pc4,
    output logic [3:0]                IF_ins_type,
    output logic [3:0]                IF_ins_number,
    output logic [$clog2(QDEPTH):0]   if_count
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] QD = CW'(QDEPTH);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic [3:0]  typ;
        logic [3:0]  num;
    } q_ent_t;

    q_ent_t        q [QDEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, count_nxt;
    logic [31:0]   fpc, rpc, new_pc;
    logic          drop;
    logic [3:0]    seq;
    logic          acc, enq, deq, req_nxt;

    function automatic logic [3:0] ins_type(input logic [31:0] w);
        logic [3:0] t;
        casez (w[31:26])
            6'b000000:         t = 4'd1;
            6'b100011:         t = 4'd3;
            6'b101011:         t = 4'd4;
            6'b000100,
            6'b000101:         t = 4'd5;
            6'b000010:         t = 4'd6;
            6'b001???:         t = 4'd2;
            default:           t = 4'd0;
        endcase
        if (w == 32'h0) t = 4'd0;
        return t;
    endfunction

    assign new_pc    = {ID_new_pc[31:2], 2'b00};
    assign imem_addr = {fpc[31:2], 2'b00};
    assign if_count  = count;

    // Redirect beats stall beats dequeue; an ack landing under a redirect or
    // while a redirect is pending never reaches the queue.
    assign acc       = imem_req & imem_ack;
    assign enq       = acc & ~drop & ~cu_branch;
    assign deq       = (count != '0) & ~cu_wpcir & ~cu_branch;
    assign count_nxt = cu_branch ? '0 : count + CW'(enq) - CW'(deq);
    // Hold an unacked request; otherwise ask again only if the slot will fit.
    assign req_nxt   = (imem_req & ~imem_ack) | (count_nxt < QD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc      <= RESET_PC;
            rpc      <= RESET_PC;
            drop     <= 1'b0;
            seq      <= 4'd0;
            imem_req <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            imem_req <= req_nxt;
            count    <= count_nxt;
            if (cu_branch) begin
                head <= '0;
                tail <= '0;
                if (imem_req & ~imem_ack) begin
                    rpc  <= new_pc;
                    drop <= 1'b1;
                end else begin
                    fpc  <= new_pc;
                    drop <= 1'b0;
                end
            end else begin
                if (acc) begin
                    if (drop) begin
                        fpc  <= rpc;
                        drop <= 1'b0;
                    end else begin
                        fpc  <= fpc + 32'd4;
                        seq  <= seq + 4'd1;
                        tail <= tail + PW'(1);
                    end
                end
                if (deq) head <= head + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) q[tail] <= '{inst: imem_rdata, pc4: fpc + 32'd4,
                              typ: ins_type(imem_rdata), num: seq};
    end

    always_comb begin
        if_inst       = 32'h0;
        if_pc4        = fpc + 32'd4;
        IF_ins_type   = 4'd0;
        IF_ins_number = seq;
        if (count != '0) begin
            if_inst       = q[head].inst;
            if_pc4        = q[head].pc4;
            IF_ins_type   = q[head].typ;
            IF_ins_number = q[head].num;
        end
    end
endmodule
